conv_pool_ctrl: RTL and testbench

- Frame sequencer for the conv_pool convolution+pooling datapath.
- Holds shadow and active kernel/shift configuration registers, accepts a frame start command and issues the input-block read stream (input_re/input_addr) to the image memory.
- Monitors the three output write ports and signals frame completion or error; sits between the host/config interface and conv_pool.

---
 rtl/conv_pool_ctrl_if.sv | 42 ++++
 rtl/conv_pool_ctrl.sv | 173 +++++++++++++++++
 tb/tb_conv_pool_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_ctrl_if.sv
// Host/config and conv_pool datapath signals of the conv_pool frame sequencer.
// slave = the sequencer itself, master = the host plus datapath side driving it.
interface conv_pool_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int KW     = 72
);
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [KW-1:0]     cfg_data;
  logic              start;
  logic [ADDR_W:0]   blk_count;
  logic              stall;
  logic              busy;
  logic              done;
  logic              err;
  logic [KW-1:0]     conv_kernel_0;
  logic [KW-1:0]     conv_kernel_1;
  logic [KW-1:0]     conv_kernel_2;
  logic [1:0]        shift;
  logic              input_re;
  logic [ADDR_W-1:0] input_addr;
  logic              output_we_0;
  logic              output_we_1;
  logic              output_we_2;
  logic [ADDR_W-1:0] output_addr_0;
  logic [ADDR_W:0]   wr_cnt;
  logic [31:0]       perf_stall_cycles;

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, start, blk_count, stall,
    input  output_we_0, output_we_1, output_we_2, output_addr_0,
    output busy, done, err, conv_kernel_0, conv_kernel_1, conv_kernel_2, shift,
    output input_re, input_addr, wr_cnt, perf_stall_cycles
  );

  modport master (
    output cfg_we, cfg_sel, cfg_data, start, blk_count, stall,
    output output_we_0, output_we_1, output_we_2, output_addr_0,
    input  busy, done, err, conv_kernel_0, conv_kernel_1, conv_kernel_2, shift,
    input  input_re, input_addr, wr_cnt, perf_stall_cycles
  );
endinterface

// File: rtl/conv_pool_ctrl.sv
// Frame sequencer for conv_pool: shadow/active config, input read issue, output write monitor.
// Define CONV_CTRL_PERF_EN to build the stall-cycle performance counter.
module conv_pool_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int NUM_BLKS = 65536,
  parameter int KW       = 72,
  parameter int TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  conv_pool_ctrl_if.slave bus
);

  localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_BLKS  = (ADDR_W+1)'(NUM_BLKS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic [ADDR_W:0]   blk_cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [1:0]        shift_sh_q;
  logic [1:0]        shift_act_q;

  logic idle_like, monitor_on, start_ok, start_bad;
  logic wr_evt, lane_err, stray_wr, addr_err;
  logic issue, last_issue, wr_last;

  always_comb begin
    idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    monitor_on = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    start_ok   = idle_like && bus.start && (bus.blk_count != '0) && (bus.blk_count <= MAX_BLKS);
    start_bad  = idle_like && bus.start && !start_ok;
    wr_evt     = monitor_on && bus.output_we_0;
    lane_err   = (bus.output_we_1 != bus.output_we_0) || (bus.output_we_2 != bus.output_we_0);
    stray_wr   = !monitor_on && (bus.output_we_0 || bus.output_we_1 || bus.output_we_2);
    addr_err   = wr_evt && (bus.output_addr_0 != wr_cnt_q[ADDR_W-1:0]);
    issue      = (state_q == S_ISSUE) && !bus.stall;
    // Zero-extend the address so a 65536-block frame ends on 0xFFFF.
    last_issue = issue && ({1'b0, addr_q} == (blk_cnt_q - 1'b1));
    wr_last    = wr_evt && ((wr_cnt_q + 1'b1) == blk_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_cnt_q  <= '0;
      blk_cnt_q <= '0;
      idle_q    <= '0;
    end else begin
      if (start_ok) begin
        err_q     <= 1'b0;
        wr_cnt_q  <= '0;
        blk_cnt_q <= bus.blk_count;
      end
      if (start_bad || lane_err || stray_wr || addr_err) err_q <= 1'b1;
      if (wr_evt) wr_cnt_q <= wr_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          addr_q  <= '0;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (issue) addr_q <= addr_q + 1'b1;
          if (wr_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (last_issue) begin
            state_q <= S_DRAIN;
            idle_q  <= '0;
          end
        end
        S_DRAIN: begin
          if (wr_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (wr_evt) begin
            idle_q <= '0;
          end else if (idle_q == IDLE_LAST) begin
            // Datapath went quiet before delivering every block.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_kern
    logic [KW-1:0] sh_q;
    logic [KW-1:0] act_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q  <= '0;
        act_q <= '0;
      end else begin
        if (bus.cfg_we && (bus.cfg_sel == 2'(gi))) sh_q <= bus.cfg_data;
        if (state_q == S_LOAD) act_q <= sh_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_sh_q  <= '0;
      shift_act_q <= '0;
    end else begin
      if (bus.cfg_we && (bus.cfg_sel == 2'd3)) shift_sh_q <= bus.cfg_data[1:0];
      if (state_q == S_LOAD) shift_act_q <= shift_sh_q;
    end
  end

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if ((state_q == S_ISSUE) && bus.stall && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end
  assign bus.perf_stall_cycles = perf_q;
`else
  assign bus.perf_stall_cycles = '0;
`endif

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.input_re      = issue;
  assign bus.input_addr    = addr_q;
  assign bus.wr_cnt        = wr_cnt_q;
  assign bus.shift         = shift_act_q;
  assign bus.conv_kernel_0 = g_kern[0].act_q;
  assign bus.conv_kernel_1 = g_kern[1].act_q;
  assign bus.conv_kernel_2 = g_kern[2].act_q;

endmodule

// File: tb/tb_conv_pool_ctrl.sv
// Directed bench for conv_pool_ctrl: frame vectors with a simple write-back model,
// plus hand sequences for reset, bad start, stray writes and reset mid-frame.
module tb_conv_pool_ctrl;
  localparam int ADDR_W = 16;
  localparam int KW     = 72;
  localparam logic [KW-1:0] K0   = 72'h010203040506070809;
  localparam logic [KW-1:0] ONES = '1;
`ifdef CONV_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_pool_ctrl_if #(.ADDR_W(ADDR_W), .KW(KW)) bus ();
  conv_pool_ctrl #(.ADDR_W(ADDR_W), .NUM_BLKS(65536), .KW(KW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            n;
    int            stall_lo;
    int            stall_hi;
    int            wr_limit;
    int            mode;       // 0 clean, 1 skip write addr 2, 2 lane-1 mismatch on 2nd write
    int            cfg_at;     // cycle of a kernel1 = all-ones shadow write, -1 none
    int            start_at;   // cycle of an extra start while busy, -1 none
    int            exp_reads;
    int            exp_done_at;
    logic          exp_err;
    int            exp_wr_cnt;
    int            exp_last_rd;
    int            exp_perf;
    logic [KW-1:0] exp_k0;
    logic [KW-1:0] exp_k1;
    logic [1:0]    exp_shift;
  } vec_t;

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.blk_count = '0; bus.stall = 1'b0;
    bus.output_we_0 = 1'b0; bus.output_we_1 = 1'b0; bus.output_we_2 = 1'b0;
    bus.output_addr_0 = '0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int rd_cnt = 0, seq_bad = 0, done_cnt = 0, done_at = -1, last_rd = -1, wr_idx = 0, c = 0;
    bit pend = 1'b0;
    int budget = v.n + 200;
    while (c < budget && !(done_cnt > 0 && c >= done_at + 3)) begin
      @(negedge clk);
      bus.start     = (c == 0) || (c == v.start_at);
      bus.blk_count = (ADDR_W+1)'(v.n);
      bus.stall     = (c - 1 >= v.stall_lo) && (c - 1 <= v.stall_hi);
      bus.cfg_we    = (c == v.cfg_at);
      bus.cfg_sel   = 2'd1;
      bus.cfg_data  = ONES;
      if (pend && wr_idx < v.wr_limit) begin
        bus.output_we_0   = 1'b1;
        bus.output_we_1   = !(v.mode == 2 && wr_idx == 1);
        bus.output_we_2   = 1'b1;
        bus.output_addr_0 = ADDR_W'((v.mode == 1 && wr_idx >= 2) ? wr_idx + 1 : wr_idx);
        wr_idx++;
      end else begin
        bus.output_we_0 = 1'b0; bus.output_we_1 = 1'b0; bus.output_we_2 = 1'b0;
        bus.output_addr_0 = '0;
      end
      #1;
      if (c == 1) begin
        check("busy_in_load", KW'(bus.busy), KW'(1));
        check("err_cleared_on_start", KW'(bus.err), KW'(0));
      end
      if (c == 2) begin
        check("kernel0_after_load", bus.conv_kernel_0, v.exp_k0);
        check("kernel1_after_load", bus.conv_kernel_1, v.exp_k1);
        check("shift_after_load", KW'(bus.shift), KW'(v.exp_shift));
      end
      if (bus.input_re) begin
        if (bus.input_addr !== ADDR_W'(rd_cnt) || rd_cnt >= v.n) seq_bad++;
        last_rd = int'(bus.input_addr);
        rd_cnt++;
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      c++;
    end
    idle_inputs();
    check("read_count", KW'(rd_cnt), KW'(v.exp_reads));
    check("read_seq_errors", KW'(seq_bad), KW'(0));
    check("last_read_addr", KW'(last_rd), KW'(v.exp_last_rd));
    check("done_pulses", KW'(done_cnt), KW'(1));
    check("done_cycle", KW'(done_at), KW'(v.exp_done_at));
    check("err_after_frame", KW'(bus.err), KW'(v.exp_err));
    check("wr_cnt_after_frame", KW'(bus.wr_cnt), KW'(v.exp_wr_cnt));
    check("busy_after_frame", KW'(bus.busy), KW'(0));
    check("perf_stall_cycles", KW'(bus.perf_stall_cycles), KW'(PERF ? v.exp_perf : 0));
    check("kernel1_end_of_frame", bus.conv_kernel_1, v.exp_k1);
    $display("frame %0d: blk_count=%0d reads=%0d done_at=%0d err=%0b wr_cnt=%0d perf=%0d",
             idx, v.n, rd_cnt, done_at, bus.err, bus.wr_cnt, bus.perf_stall_cycles);
  endtask

  vec_t vecs[8];

  initial begin
    int found;
    int dones;
    //            n  slo shi  wrl md cfg st  reads done err wr  last perf k0  k1    sh
    vecs[0] = '{4,     -1, -2, 4,     0, -1, -1, 4,     7,     1'b0, 4,     3,     0, K0, '0,   2'd2};
    vecs[1] = '{8,      2,  4, 8,     0, -1, -1, 8,     14,    1'b0, 8,     7,     3, K0, '0,   2'd2};
    vecs[2] = '{4,     -1, -2, 4,     0,  3,  4, 4,     7,     1'b0, 4,     3,     0, K0, '0,   2'd2};
    vecs[3] = '{2,     -1, -2, 2,     0, -1, -1, 2,     5,     1'b0, 2,     1,     0, K0, ONES, 2'd2};
    vecs[4] = '{4,     -1, -2, 4,     1, -1, -1, 4,     7,     1'b1, 4,     3,     0, K0, ONES, 2'd2};
    vecs[5] = '{4,     -1, -2, 4,     2, -1, -1, 4,     7,     1'b1, 4,     3,     0, K0, ONES, 2'd2};
    vecs[6] = '{4,     -1, -2, 3,     0, -1, -1, 4,     70,    1'b1, 3,     3,     0, K0, ONES, 2'd2};
    vecs[7] = '{65536, -1, -2, 65536, 0, -1, -1, 65536, 65539, 1'b0, 65536, 65535, 0, K0, ONES, 2'd2};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", KW'(bus.busy), KW'(0));
    check("reset_done", KW'(bus.done), KW'(0));
    check("reset_err", KW'(bus.err), KW'(0));
    check("reset_input_re", KW'(bus.input_re), KW'(0));
    check("reset_input_addr", KW'(bus.input_addr), KW'(0));
    check("reset_wr_cnt", KW'(bus.wr_cnt), KW'(0));
    check("reset_kernel0", bus.conv_kernel_0, '0);
    check("reset_kernel2", bus.conv_kernel_2, '0);
    check("reset_shift", KW'(bus.shift), KW'(0));
    check("reset_perf", KW'(bus.perf_stall_cycles), KW'(0));
    rst = 1'b0;

    // Shadow writes alone must not reach the active kernels.
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = K0;
    @(negedge clk);
    bus.cfg_sel = 2'd3; bus.cfg_data = KW'(2);
    @(negedge clk);
    idle_inputs();
    #1;
    check("active_kernel0_before_start", bus.conv_kernel_0, '0);
    $display("cfg: kernel0 and shift shadows written");

    // Out-of-range start.
    @(negedge clk);
    bus.start = 1'b1; bus.blk_count = '0;
    @(negedge clk);
    idle_inputs();
    #1;
    check("bad_start_err", KW'(bus.err), KW'(1));
    check("bad_start_busy", KW'(bus.busy), KW'(0));
    @(negedge clk);
    #1;
    check("bad_start_busy_later", KW'(bus.busy), KW'(0));
    $display("bad start: blk_count=0 err=%0b busy=%0b", bus.err, bus.busy);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Stray write while idle.
    @(negedge clk);
    bus.output_we_0 = 1'b1; bus.output_we_1 = 1'b1; bus.output_we_2 = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("stray_write_err", KW'(bus.err), KW'(1));
    $display("stray write in idle: err=%0b", bus.err);

    // Reset in the middle of ISSUE.
    @(negedge clk);
    bus.start = 1'b1; bus.blk_count = (ADDR_W+1)'(200);
    @(negedge clk);
    idle_inputs();
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.input_re && bus.input_addr == ADDR_W'(100)) found = 1;
    end
    check("reached_addr_100", KW'(found), KW'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midreset_busy", KW'(bus.busy), KW'(0));
    check("midreset_input_re", KW'(bus.input_re), KW'(0));
    check("midreset_kernel0", bus.conv_kernel_0, '0);
    check("midreset_kernel1", bus.conv_kernel_1, '0);
    check("midreset_input_addr", KW'(bus.input_addr), KW'(0));
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.busy || bus.input_re) dones++;
    end
    check("midreset_no_activity", KW'(dones), KW'(0));
    $display("reset mid-issue: busy=%0b input_re=%0b", bus.busy, bus.input_re);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
